// File: rtl/alu_pwr_pkg.sv
// Shared types and timing defaults for the ALU power-sequencing controller.
package alu_pwr_pkg;

  typedef enum logic [2:0] {
    OFF     = 3'd0,
    PWR_UP  = 3'd1,
    RST_REL = 3'd2,
    ON      = 3'd3,
    DRAIN   = 3'd4,
    ISO     = 3'd5
  } pwr_state_e;

  localparam int unsigned DEF_PWR_UP_CYC = 4;
  localparam int unsigned DEF_RST_HOLD   = 2;
  localparam int unsigned DEF_ISO_SETUP  = 2;
  localparam int unsigned DEF_DRAIN_MAX  = 16;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
    return $clog2(max4(a, b, c, d) + 1);
  endfunction

endpackage

// File: rtl/alu_pwr_ctrl_if.sv
// Isolation / power-enable control interface between the controller and the ALU side.
interface alu_pwr_ctrl_if;
  logic pwr_req;
  logic alu_busy;
  logic alu_pwr_en;
  logic iso_en;
  logic alu_rst_n;
  logic pwr_on;
  logic pwr_off;
  logic drain_timeout;

  modport master (
    input  pwr_req, alu_busy,
    output alu_pwr_en, iso_en, alu_rst_n, pwr_on, pwr_off, drain_timeout
  );

  modport slave (
    output pwr_req, alu_busy,
    input  alu_pwr_en, iso_en, alu_rst_n, pwr_on, pwr_off, drain_timeout
  );
endinterface

// File: rtl/alu_pwr_ctrl_timer.sv
// Loadable down-counter shared by every timed state; saturates at zero.
module pwr_seq_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alu_pwr_ctrl.sv
// Power-sequencing FSM for the gated ALU domain: isolate -> reset -> power off,
// and power on -> release reset -> de-isolate.
module alu_pwr_ctrl
  import alu_pwr_pkg::*;
#(
  parameter int unsigned PWR_UP_CYC = DEF_PWR_UP_CYC,
  parameter int unsigned RST_HOLD   = DEF_RST_HOLD,
  parameter int unsigned ISO_SETUP  = DEF_ISO_SETUP,
  parameter int unsigned DRAIN_MAX  = DEF_DRAIN_MAX
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_pwr_ctrl_if.master bus
);

  localparam int unsigned CW = cnt_width(PWR_UP_CYC, RST_HOLD, ISO_SETUP, DRAIN_MAX);

  pwr_state_e    state, state_next;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_done;

  logic pwr_en_q, iso_q, rst_n_q, on_q, off_q, to_q;
  logic pwr_en_d, iso_d, rst_n_d, on_d, off_d, to_d;

  pwr_seq_timer #(.WIDTH(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Timer is loaded with dwell-1 on the entry edge, so done rises on the
  // dwell-th cycle and the exit edge lands exactly dwell edges after entry.
  always_comb begin
    state_next = state;
    tmr_load   = 1'b0;
    tmr_val    = '0;
    to_d       = 1'b0;
    unique case (state)
      OFF: if (bus.pwr_req) begin
        state_next = PWR_UP;
        tmr_load   = 1'b1;
        tmr_val    = CW'(PWR_UP_CYC - 1);
      end
      PWR_UP: if (tmr_done) begin
        state_next = RST_REL;
        tmr_load   = 1'b1;
        tmr_val    = CW'(RST_HOLD - 1);
      end
      RST_REL: if (tmr_done) state_next = ON;
      ON: if (!bus.pwr_req) begin
        state_next = DRAIN;
        tmr_load   = 1'b1;
        tmr_val    = CW'(DRAIN_MAX - 1);
      end
      DRAIN: begin
        if (bus.pwr_req) begin
          state_next = ON;
        end else if (!bus.alu_busy || tmr_done) begin
          state_next = ISO;
          tmr_load   = 1'b1;
          tmr_val    = CW'(ISO_SETUP - 1);
          to_d       = bus.alu_busy;
        end
      end
      ISO: if (tmr_done) state_next = OFF;
      default: state_next = OFF;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    pwr_en_d = 1'b0;
    iso_d    = 1'b1;
    rst_n_d  = 1'b0;
    on_d     = 1'b0;
    off_d    = 1'b0;
    unique case (state_next)
      OFF:     off_d = 1'b1;
      PWR_UP:  pwr_en_d = 1'b1;
      RST_REL: begin pwr_en_d = 1'b1; rst_n_d = 1'b1; end
      ON:      begin pwr_en_d = 1'b1; rst_n_d = 1'b1; iso_d = 1'b0; on_d = 1'b1; end
      DRAIN:   begin pwr_en_d = 1'b1; rst_n_d = 1'b1; iso_d = 1'b0; end
      ISO:     begin pwr_en_d = 1'b1; rst_n_d = 1'b1; end
      default: off_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= OFF;
      pwr_en_q <= 1'b0;
      iso_q    <= 1'b1;
      rst_n_q  <= 1'b0;
      on_q     <= 1'b0;
      off_q    <= 1'b1;
      to_q     <= 1'b0;
    end else begin
      state    <= state_next;
      pwr_en_q <= pwr_en_d;
      iso_q    <= iso_d;
      rst_n_q  <= rst_n_d;
      on_q     <= on_d;
      off_q    <= off_d;
      to_q     <= to_d;
    end
  end

  assign bus.alu_pwr_en    = pwr_en_q;
  assign bus.iso_en        = iso_q;
  assign bus.alu_rst_n     = rst_n_q;
  assign bus.pwr_on        = on_q;
  assign bus.pwr_off       = off_q;
  assign bus.drain_timeout = to_q;

endmodule

// File: tb/tb_alu_pwr_ctrl.sv
// Self-checking bench for alu_pwr_ctrl: directed sequence tests plus a
// randomized run against an elapsed-time reference model.
module tb_alu_pwr_ctrl;

  localparam int PU = 4;
  localparam int RH = 2;
  localparam int IS = 2;
  localparam int DM = 16;

  localparam int M_OFF   = 0;
  localparam int M_WAKE  = 1;
  localparam int M_ON    = 2;
  localparam int M_DRAIN = 3;
  localparam int M_ISO   = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  int   m_mode;
  int   m_age;
  logic m_to;

  alu_pwr_ctrl_if bus ();

  alu_pwr_ctrl #(
    .PWR_UP_CYC (PU),
    .RST_HOLD   (RH),
    .ISO_SETUP  (IS),
    .DRAIN_MAX  (DM)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {alu_pwr_en, iso_en, alu_rst_n, pwr_on, pwr_off, drain_timeout}
  function automatic logic [5:0] outs();
    return {bus.alu_pwr_en, bus.iso_en, bus.alu_rst_n, bus.pwr_on, bus.pwr_off, bus.drain_timeout};
  endfunction

  task automatic model_reset();
    m_mode = M_OFF;
    m_age  = 0;
    m_to   = 1'b0;
  endtask

  // Sequencing expressed as elapsed cycles since each phase began.
  task automatic model_step(input logic req, input logic busy);
    m_to = 1'b0;
    case (m_mode)
      M_OFF:  if (req) begin m_mode = M_WAKE; m_age = 0; end
      M_WAKE: begin m_age++; if (m_age == PU + RH) m_mode = M_ON; end
      M_ON:   if (!req) begin m_mode = M_DRAIN; m_age = 0; end
      M_DRAIN: begin
        m_age++;
        if (req) m_mode = M_ON;
        else if (!busy) begin m_mode = M_ISO; m_age = 0; end
        else if (m_age == DM) begin m_mode = M_ISO; m_age = 0; m_to = 1'b1; end
      end
      M_ISO:  begin m_age++; if (m_age == IS) m_mode = M_OFF; end
      default: m_mode = M_OFF;
    endcase
  endtask

  function automatic logic [5:0] model_outs();
    case (m_mode)
      M_OFF:   return 6'b010010;
      M_WAKE:  return (m_age < PU) ? 6'b110000 : 6'b111000;
      M_ON:    return 6'b101100;
      M_DRAIN: return 6'b101000;
      default: return {5'b11100, m_to};
    endcase
  endfunction

  task automatic tick();
    logic r, b;
    r = bus.pwr_req;
    b = bus.alu_busy;
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(r, b);
    #1;
  endtask

  task automatic do_reset();
    bus.pwr_req  = 1'b0;
    bus.alu_busy = 1'b0;
    rst_n = 1'b0;
    model_reset();
    #3;
    rst_n = 1'b1;
  endtask

  task automatic wake_to_on();
    bus.pwr_req = 1'b1;
    repeat (PU + RH + 1) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pwr_req  = 1'b1;
    bus.alu_busy = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (outs() !== 6'b010010) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=%b", outs(), 6'b010010);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.alu_pwr_en !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_pwr_en got=%b exp=1", bus.alu_pwr_en);
    end
  endtask

  task automatic test_wake();
    logic [5:0] exp;
    do_reset();
    bus.pwr_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      exp = {1'b1, 1'(i < PU + RH), 1'(i >= PU), 1'(i >= PU + RH), 1'b0, 1'b0};
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL wake_e%0d got=%b exp=%b", i, outs(), exp);
      end
    end
  endtask

  task automatic test_idle_sleep();
    logic [5:0] exp;
    bus.pwr_req  = 1'b0;
    bus.alu_busy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = {1'(i < IS + 1), 1'(i >= 1), 1'(i < IS + 1), 1'b0, 1'(i >= IS + 1), 1'b0};
      checks++;
      if (outs() !== exp) begin
        failures++;
        $display("FAIL idle_sleep_e%0d got=%b exp=%b", i, outs(), exp);
      end
    end
  endtask

  task automatic test_busy_drain();
    do_reset();
    wake_to_on();
    bus.pwr_req = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.alu_busy = (i >= 1 && i <= 5);
      tick();
      checks++;
      if ({bus.iso_en, bus.drain_timeout} !== {1'(i >= 6), 1'b0}) begin
        failures++;
        $display("FAIL busy_drain_e%0d iso_to got=%b%b exp=%b0", i, bus.iso_en, bus.drain_timeout, 1'(i >= 6));
      end
    end
    do_reset();
    wake_to_on();
    bus.pwr_req  = 1'b0;
    bus.alu_busy = 1'b1;
    for (int i = 0; i < DM + 2; i++) begin
      tick();
      checks++;
      if ({bus.alu_pwr_en, bus.iso_en, bus.drain_timeout} !== {1'b1, 1'(i >= DM), 1'(i == DM)}) begin
        failures++;
        $display("FAIL stuck_drain_e%0d pwr_iso_to got=%b%b%b exp=1%b%b", i,
                 bus.alu_pwr_en, bus.iso_en, bus.drain_timeout, 1'(i >= DM), 1'(i == DM));
      end
    end
  endtask

  task automatic test_races();
    do_reset();
    wake_to_on();
    bus.pwr_req  = 1'b0;
    bus.alu_busy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 2) bus.pwr_req = 1'b1;
      tick();
      checks++;
      if ({bus.iso_en, bus.pwr_on} !== {1'b0, 1'(i >= 2)}) begin
        failures++;
        $display("FAIL drain_race_e%0d iso_on got=%b%b exp=0%b", i, bus.iso_en, bus.pwr_on, 1'(i >= 2));
      end
    end
    do_reset();
    bus.pwr_req  = 1'b1;
    bus.alu_busy = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i == 2) bus.pwr_req = 1'b0;
      tick();
      checks++;
      if ({bus.alu_pwr_en, bus.pwr_on, bus.iso_en} !== {1'b1, 1'(i == 6), 1'(i < 6 || i == 8)}) begin
        failures++;
        $display("FAIL wake_race_e%0d pwr_on_iso got=%b%b%b exp=1%b%b", i,
                 bus.alu_pwr_en, bus.pwr_on, bus.iso_en, 1'(i == 6), 1'(i < 6 || i == 8));
      end
    end
  endtask

  task automatic test_reset_mid_iso();
    do_reset();
    wake_to_on();
    bus.pwr_req  = 1'b0;
    bus.alu_busy = 1'b0;
    tick();
    tick();
    checks++;
    if (outs() !== 6'b111000) begin
      failures++;
      $display("FAIL mid_iso_entry got=%b exp=%b", outs(), 6'b111000);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (outs() !== 6'b010010) begin
      failures++;
      $display("FAIL mid_iso_async got=%b exp=%b", outs(), 6'b010010);
    end
    @(posedge clk);
    #1;
    checks++;
    if (outs() !== 6'b010010) begin
      failures++;
      $display("FAIL mid_iso_held got=%b exp=%b", outs(), 6'b010010);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (outs() !== 6'b010010) begin
      failures++;
      $display("FAIL mid_iso_after got=%b exp=%b", outs(), 6'b010010);
    end
  endtask

  task automatic test_random();
    int busy_bias;
    do_reset();
    busy_bias = 2;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 11) == 0) bus.pwr_req = ~bus.pwr_req;
      if ($urandom_range(0, 39) == 0) busy_bias = $urandom_range(0, 4);
      bus.alu_busy = ($urandom_range(0, 3) < busy_bias);
      if ($urandom_range(0, 249) == 0) begin
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        rst_n = 1'b1;
      end
      tick();
      checks++;
      if (outs() !== model_outs()) begin
        failures++;
        $display("FAIL random_n%0d got=%b exp=%b", n, outs(), model_outs());
      end
      checks++;
      if (!bus.iso_en && !(bus.alu_pwr_en && bus.alu_rst_n)) begin
        failures++;
        $display("FAIL random_iso_guard_n%0d got=%b exp=iso_en set while unpowered", n, outs());
      end
    end
  endtask

  initial begin
    bus.pwr_req  = 1'b0;
    bus.alu_busy = 1'b0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_wake();
    test_idle_sleep();
    test_busy_drain();
    test_races();
    test_reset_mid_iso();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_pwr_ctrl.md
# alu_pwr_ctrl

Power-sequencing controller for the gated ALU domain. It drives `alu_pwr_en`, `iso_en` and a domain reset, and it sequences wake and sleep in the safe order: isolate → reset → power off, and power on → release reset → de-isolate. It sits in the always-on domain beside `aon_block`, between a system power request and the ALU. It owns the control end of the isolation/power-enable interface that the ALU wrapper consumes.

## Interface
Parameters:
- `PWR_UP_CYC`, default 4: cycles of power-on settling before domain reset is released (≥1).
- `RST_HOLD`, default 2: cycles after reset release before isolation is dropped (≥1).
- `ISO_SETUP`, default 2: cycles isolation is held before power is removed (≥1).
- `DRAIN_MAX`, default 16: maximum cycles spent waiting for `alu_busy` to clear (≥1).

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pwr_req`  in  1  level request: 1 = ALU domain on, 0 = off.
- `alu_busy`  in  1  ALU operation in flight; sampled only in DRAIN.
- `alu_pwr_en`  out  1  power-switch enable for the ALU domain.
- `iso_en`  out  1  isolation clamp enable.
- `alu_rst_n`  out  1  active-low domain reset to the ALU.
- `pwr_on`  out  1  1 only in state ON.
- `pwr_off`  out  1  1 only in state OFF.
- `drain_timeout`  out  1  one-cycle pulse when DRAIN exits on timeout.

## Operation
- Moore FSM. All outputs are registered and update on the same edge as the state register. No output is decoded combinationally.

State outputs, given as (pwr_en, iso_en, alu_rst_n):
- OFF (0,1,0)
- PWR_UP (1,1,0)
- RST_REL (1,1,1)
- ON (1,0,1)
- DRAIN (1,0,1)
- ISO (1,1,1)

Transitions (each state's dwell time is counted from its entry edge):
- OFF → PWR_UP when `pwr_req`=1.
- PWR_UP → RST_REL after `PWR_UP_CYC` cycles.
- RST_REL → ON after `RST_HOLD` cycles.
- ON → DRAIN when `pwr_req`=0.
- DRAIN → ON if `pwr_req`=1. This has highest priority, and `iso_en` never pulses.
- DRAIN → ISO if `alu_busy`=0. Otherwise DRAIN → ISO with a `drain_timeout` pulse after `DRAIN_MAX` cycles.
- ISO → OFF after `ISO_SETUP` cycles.

Boundary rules:
- Wake and sleep sequences, once started, are not aborted except in DRAIN. A request change during PWR_UP, RST_REL or ISO is acted on only after reaching ON or OFF.
- `alu_busy` is ignored in every state except DRAIN, because it is undefined while the domain is off or isolated.
- `iso_en` is 1 on every edge where `alu_pwr_en` or `alu_rst_n` changes. There is never a cycle with `iso_en`=0 while `alu_pwr_en`=0 or `alu_rst_n`=0.
- Asynchronous reset, including mid-sequence: immediately enter OFF. Outputs go to `alu_pwr_en`=0, `iso_en`=1, `alu_rst_n`=0, `pwr_off`=1, `pwr_on`=0, `drain_timeout`=0, and the counter is cleared.

## Timing
Latencies are in edges after the edge that samples the `pwr_req` change (edge 0), using default parameters:
- Wake:
  - edge 0: `alu_pwr_en`↑.
  - edge 4: `alu_rst_n`↑.
  - edge 6: `iso_en`↓ and `pwr_on`↑.
  - In general, `iso_en` falls at edge `PWR_UP_CYC+RST_HOLD`.
- Sleep, idle ALU:
  - edge 0: DRAIN, `pwr_on`↓.
  - edge 1: `iso_en`↑.
  - edge 3: `alu_pwr_en`↓, `alu_rst_n`↓, `pwr_off`↑.
- Sleep, busy ALU: `iso_en` rises on the first edge in DRAIN that samples `alu_busy`=0.
- Sleep, stuck-busy ALU: `iso_en` rises at edge `DRAIN_MAX` with `drain_timeout`=1 for exactly that cycle.
- Counter width is `$clog2(max(PWR_UP_CYC, RST_HOLD, ISO_SETUP, DRAIN_MAX)+1)`. The counter is loaded on state entry, decrements each cycle, and never wraps.

## Structure
- Package `alu_pwr_pkg` holds:
  - the state enum (OFF, PWR_UP, RST_REL, ON, DRAIN, ISO), 3 bits, with OFF = 0;
  - the default timing constants.
- Sub-module `pwr_seq_timer`: a loadable down-counter with a `done` flag, shared by all timed states.
- The top level of `alu_pwr_ctrl` contains the FSM and the output registers.

## Test plan
- **Reset:** hold `rst_n`=0 with `pwr_req`=1 → `alu_pwr_en`=0, `iso_en`=1, `alu_rst_n`=0, `pwr_off`=1. Release reset → `alu_pwr_en`↑ on the first edge.
- **Wake:** `pwr_req` 0→1 sampled at edge 0 → `alu_pwr_en`=1 at 0, `alu_rst_n`=1 at 4, `iso_en`=0 and `pwr_on`=1 at 6.
- **Idle sleep:** from ON, `pwr_req`→0 with `alu_busy`=0 → `iso_en`=1 at 1, `alu_pwr_en`=0 and `alu_rst_n`=0 at 3.
- **Busy drain:** `alu_busy`=1 for 5 cycles after DRAIN entry → `iso_en` rises at edge 6 and `drain_timeout` stays 0. With `alu_busy` stuck at 1 → `iso_en`=1 and `drain_timeout` pulse at edge 16.
- **Request races:**
  - `pwr_req` returns to 1 at edge 2 in DRAIN → ON at edge 2, and `iso_en` stays 0 throughout.
  - `pwr_req` drops at edge 2 of a wake → ON at 6, then DRAIN at 7.
- **Reset mid-ISO:** assert `rst_n`=0 between edges → all outputs take OFF values asynchronously, with no glitch on `iso_en`.
